gs_raw_signal_capture: RTL and testbench
========================================

// Module: gs_raw_signal_capture
// PURPOSE
//  Capture stage upstream of the Xillybus gs_raw_signal read stream. A 32-bit command on the
//  gs_start_test write stream arms a capture of N ADC samples. Samples are buffered in an
//  internal FIFO and served through the 16-bit user_r_gs_raw_signal_* interface, with EOF
//  raised once all N samples have been read. All logic is on bus_clk.
// PARAMETERS
//  DATA_W      16  sample width; equals user_r_gs_raw_signal_data width
//  DEPTH_LOG2  10  FIFO depth = 2**DEPTH_LOG2 words
// PORTS
//  bus_clk                     in   1       single clock
//  bus_rst_n                   in   1       synchronous, active-low reset
//  user_w_gs_start_test_wren   in   1       command strobe
//  user_w_gs_start_test_data   in   32      [15:0] sample count N; [31] abort
//  user_w_gs_start_test_full   out  1       tied 0; commands are always accepted
//  user_w_gs_start_test_open   in   1       write file open (informational)
//  adc_valid                   in   1       one-cycle sample strobe
//  adc_data                    in   DATA_W  sample; valid with adc_valid
//  user_r_gs_raw_signal_rden   in   1       FIFO pop request
//  user_r_gs_raw_signal_data   out  DATA_W  popped word; registered
//  user_r_gs_raw_signal_empty  out  1       FIFO empty
//  user_r_gs_raw_signal_eof    out  1       end of capture
//  user_r_gs_raw_signal_open   in   1       read file open
//  busy                        out  1       state != IDLE
//  overflow                    out  1       sticky: a sample was dropped on FIFO full
// BEHAVIOUR
//  - Clock and reset: one clock, bus_clk. Reset is synchronous and active-low (bus_rst_n).
//  - Reset values: state=IDLE, FIFO count=0, empty=1, eof=0, data=0, full=0, busy=0, overflow=0.
//  - FSM states: IDLE -> CAPTURE -> DRAIN -> DONE -> IDLE.
//  - IDLE: wren with [31]=0 and N!=0 -> load remaining=N, clear overflow, go to CAPTURE.
//    A command with N=0 is ignored.
//  - CAPTURE: each adc_valid decrements remaining.
//    * FIFO not full -> adc_data is pushed.
//    * FIFO full -> sample is dropped and overflow is set; remaining still decrements.
//    * remaining 1->0 -> go to DRAIN on the next cycle.
//  - DRAIN: FIFO empty -> go to DONE.
//  - DONE: eof=1 (empty is also 1). user_r_gs_raw_signal_open 1->0 -> go to IDLE.
//  - Start commands ([31]=0) received outside IDLE are ignored.
//  - Abort: wren with [31]=1 in any state -> FIFO flushed, overflow cleared, IDLE on the
//    next cycle. Abort wins over a simultaneous push, pop or state transition.
//  - Read-side close: user_r_gs_raw_signal_open 1->0 in CAPTURE or DRAIN is treated as abort.
//  - Read timing: rden with !empty pops; data is updated on the following edge (1-cycle
//    latency). rden while empty is ignored and data holds its value.
//  - Push rule: a push is accepted only if count < 2**DEPTH_LOG2. A pop in the same cycle
//    does not free space for that push.
//  - Push and pop in the same cycle: count is unchanged.
//  - Pointers wrap modulo the depth. Count is DEPTH_LOG2+1 bits wide.
//  - empty is derived from the registered count; it deasserts the cycle after the first push.
//  - busy = (state != IDLE).
// CONFIGURATION
//  GS_RAW_HEADER_EN defined:
//   - On entry to CAPTURE, two words are pushed first: 16'hA55A, then N.
//   - Header pushes never count toward remaining.
//   - An adc_valid coinciding with a header push is still pushed, after the header.
//  GS_RAW_HEADER_EN undefined: the stream contains samples only.
// TESTING
//  1. Reset -> empty=1, eof=0, busy=0, overflow=0, data=0.
//  2. Cmd 32'h0000_0004; feed 4 samples 1..4; pop 4 -> data 1,2,3,4; then empty=1, eof=1.
//     Drop read open -> busy=0.
//  3. Cmd N=1100 with DEPTH_LOG2=10 and no reads -> 1024 words stored, overflow=1;
//     the FSM still reaches DRAIN after 1100 strobes.
//  4. Cmd N=8; after 3 samples send 32'h8000_0000 -> empty=1 and IDLE next cycle, overflow=0.
//  5. During CAPTURE, issue rden and adc_valid in the same cycle at count=5 -> count stays 5,
//     data order is preserved. rden while empty -> data unchanged.
//  6. GS_RAW_HEADER_EN defined, N=2, samples 7,9 -> reads A55A, 0002, 0007, 0009, then eof=1.

Source files
------------

// File: rtl/gs_raw_signal_capture_if.sv
// gs_raw_signal_capture_if
//   Groups the Xillybus start-command write stream, the ADC sample strobe and
//   the gs_raw_signal read stream into one bundle.
//   master : host/testbench side (drives commands, samples, read requests)
//   slave  : capture block side (drives read data, empty, eof, full)
//   Signals:
//     user_w_gs_start_test_wren/data/open  command stream into the block
//     user_w_gs_start_test_full            command back-pressure (always 0)
//     adc_valid/adc_data                   one-cycle sample strobe and sample
//     user_r_gs_raw_signal_rden/open       read request and read file open
//     user_r_gs_raw_signal_data/empty/eof  popped word, FIFO empty, end of capture
interface gs_raw_signal_capture_if #(
  parameter int DATA_W = 16
);
  logic              user_w_gs_start_test_wren;
  logic [31:0]       user_w_gs_start_test_data;
  logic              user_w_gs_start_test_full;
  logic              user_w_gs_start_test_open;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic              user_r_gs_raw_signal_rden;
  logic [DATA_W-1:0] user_r_gs_raw_signal_data;
  logic              user_r_gs_raw_signal_empty;
  logic              user_r_gs_raw_signal_eof;
  logic              user_r_gs_raw_signal_open;

  modport master (
    output user_w_gs_start_test_wren, user_w_gs_start_test_data, user_w_gs_start_test_open,
    output adc_valid, adc_data,
    output user_r_gs_raw_signal_rden, user_r_gs_raw_signal_open,
    input  user_w_gs_start_test_full,
    input  user_r_gs_raw_signal_data, user_r_gs_raw_signal_empty, user_r_gs_raw_signal_eof
  );

  modport slave (
    input  user_w_gs_start_test_wren, user_w_gs_start_test_data, user_w_gs_start_test_open,
    input  adc_valid, adc_data,
    input  user_r_gs_raw_signal_rden, user_r_gs_raw_signal_open,
    output user_w_gs_start_test_full,
    output user_r_gs_raw_signal_data, user_r_gs_raw_signal_empty, user_r_gs_raw_signal_eof
  );
endinterface

// File: rtl/gs_raw_signal_capture.sv
// gs_raw_signal_capture
//   Capture stage feeding the Xillybus gs_raw_signal read stream. A start
//   command (bit 31 clear, N in [15:0]) arms a capture of N ADC samples which
//   are buffered in an internal FIFO and read out through the read stream;
//   eof rises once the capture has finished and the FIFO has been drained.
//   Bit 31 set aborts from any state; closing the read file mid-capture aborts.
// Ports
//   bus_clk    single clock
//   bus_rst_n  synchronous active-low reset
//   bus        gs_raw_signal_capture_if.slave (command, ADC and read streams)
//   busy       capture in progress (not idle)
//   overflow   sticky: a sample was dropped because the FIFO was full
// Configuration
//   GS_RAW_HEADER_EN  when defined, each capture stream starts with the two
//                     header words 16'hA55A and N ahead of the samples.
module gs_raw_signal_capture #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    bus_clk,
  input  logic                    bus_rst_n,
  gs_raw_signal_capture_if.slave  bus,
  output logic                    busy,
  output logic                    overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr, wr_ptr_inc;
  logic [CNT_W-1:0]        count;
  logic [DATA_W-1:0]       rd_data;
  logic [15:0]             remaining;
  logic                    overflow_q;
  logic                    open_q;

  logic [15:0] cmd_n;
  logic        open_fall, fifo_empty, fifo_full;
  logic        abort, start, sample, push, pop, hdr_push;
  logic [1:0]  in_words;
  logic        unused_inputs;

  assign cmd_n      = bus.user_w_gs_start_test_data[15:0];
  assign open_fall  = open_q & ~bus.user_r_gs_raw_signal_open;
  assign fifo_empty = (count == '0);
  // count never exceeds DEPTH, so its top bit alone marks a full FIFO
  assign fifo_full  = count[DEPTH_LOG2];

  // Abort has priority over everything; a read-side close only aborts while a
  // capture is still producing or draining data.
  assign abort  = (bus.user_w_gs_start_test_wren & bus.user_w_gs_start_test_data[31])
                | (open_fall & ((state == CAPTURE) | (state == DRAIN)));
  assign start  = (state == IDLE) & bus.user_w_gs_start_test_wren
                & ~bus.user_w_gs_start_test_data[31] & (cmd_n != 16'd0);
  assign sample = (state == CAPTURE) & bus.adc_valid & ~abort;
  // Space is judged on the registered count, so a same-cycle pop never frees room
  assign push   = sample & ~fifo_full;
  assign pop    = bus.user_r_gs_raw_signal_rden & ~fifo_empty & ~abort;

`ifdef GS_RAW_HEADER_EN
  // Header words are written on the accepting edge, so they always precede
  // any sample of the new capture; the FIFO is empty in IDLE so both fit.
  assign hdr_push = start;
`else
  assign hdr_push = 1'b0;
`endif

  assign in_words   = hdr_push ? 2'd2 : {1'b0, push};
  assign wr_ptr_inc = wr_ptr + 1'b1;

  // State register
  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = CAPTURE;
        CAPTURE: if (sample && (remaining == 16'd1)) state_nxt = DRAIN;
        DRAIN:   if (fifo_empty) state_nxt = DONE;
        DONE:    if (open_fall) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FIFO storage (no reset needed; validity is tracked by the pointers)
  always_ff @(posedge bus_clk) begin
    if (hdr_push) begin
      mem[wr_ptr]     <= DATA_W'(16'hA55A);
      mem[wr_ptr_inc] <= DATA_W'(cmd_n);
    end else if (push) begin
      mem[wr_ptr] <= bus.adc_data;
    end
  end

  // FIFO pointers/count, read register, sample counter and overflow flag
  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_data    <= '0;
      remaining  <= '0;
      overflow_q <= 1'b0;
      open_q     <= 1'b0;
    end else begin
      open_q <= bus.user_r_gs_raw_signal_open;
      if (abort) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (pop) begin
          rd_data <= mem[rd_ptr];
          rd_ptr  <= rd_ptr + 1'b1;
        end
        wr_ptr <= wr_ptr + DEPTH_LOG2'(in_words);
        count  <= count + CNT_W'(in_words) - CNT_W'(pop);
        if (start) begin
          remaining  <= cmd_n;
          overflow_q <= 1'b0;
        end else if (sample) begin
          remaining <= remaining - 16'd1;
          if (fifo_full) overflow_q <= 1'b1;
        end
      end
    end
  end

  assign bus.user_w_gs_start_test_full  = 1'b0;
  assign bus.user_r_gs_raw_signal_data  = rd_data;
  assign bus.user_r_gs_raw_signal_empty = fifo_empty;
  assign bus.user_r_gs_raw_signal_eof   = (state == DONE);
  assign busy                           = (state != IDLE);
  assign overflow                       = overflow_q;

  // Write-file open and the reserved command bits carry no function here
  assign unused_inputs = ^{bus.user_w_gs_start_test_open, bus.user_w_gs_start_test_data[30:16]};

endmodule

// File: tb/tb_gs_raw_signal_capture.sv
// tb_gs_raw_signal_capture
//   Self-checking bench for gs_raw_signal_capture: a directed vector table, a
//   few hand-written multi-cycle sequences and a randomized run, all compared
//   against a queue-based behavioural model of the capture stream.
module tb_gs_raw_signal_capture;

  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 10;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  localparam int M_IDLE    = 0;
  localparam int M_CAPTURE = 1;
  localparam int M_DRAIN   = 2;
  localparam int M_DONE    = 3;

  logic bus_clk = 1'b0;
  logic bus_rst_n = 1'b0;
  logic busy, overflow;

  gs_raw_signal_capture_if #(.DATA_W(DATA_W)) bus_if ();

  gs_raw_signal_capture #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .bus_clk   (bus_clk),
    .bus_rst_n (bus_rst_n),
    .bus       (bus_if),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 bus_clk = ~bus_clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: the stream contents as a queue plus capture bookkeeping
  logic [15:0] mq[$];
  int          m_mode = M_IDLE;
  int          m_rem = 0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_data = 16'h0;
  bit          m_open_prev = 1'b0;

  typedef struct {
    logic        wren;
    logic [31:0] cmd;
    logic        av;
    logic [15:0] ad;
    logic        rd;
    logic        op;
    logic        e_empty;
    logic        e_eof;
    logic        e_busy;
    logic        e_ovf;
    logic [15:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic wren, input logic [31:0] cmd, input logic av,
                              input logic [15:0] ad, input logic rd, input logic op,
                              input logic e_empty, input logic e_eof, input logic e_busy,
                              input logic e_ovf, input logic [15:0] e_data);
    vec_t v;
    v.wren = wren; v.cmd = cmd; v.av = av; v.ad = ad; v.rd = rd; v.op = op;
    v.e_empty = e_empty; v.e_eof = e_eof; v.e_busy = e_busy; v.e_ovf = e_ovf; v.e_data = e_data;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of the reference model, evaluated on the inputs of that cycle
  task automatic modelStep(input logic wren, input logic [31:0] cmd, input logic av,
                           input logic [15:0] ad, input logic rd, input logic op);
    int sz0;
    bit fall, abort_c, can_push;
    sz0 = mq.size();
    fall = m_open_prev && !op;
    m_open_prev = op;
    abort_c = (wren && cmd[31]) || (fall && (m_mode == M_CAPTURE || m_mode == M_DRAIN));
    if (abort_c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_mode = M_IDLE;
    end else begin
      can_push = (sz0 < DEPTH);
      if (rd && sz0 > 0) m_data = mq.pop_front();
      case (m_mode)
        M_IDLE: begin
          if (wren && cmd[15:0] != 16'd0) begin
            m_rem = int'(cmd[15:0]);
            m_ovf = 1'b0;
            m_mode = M_CAPTURE;
`ifdef GS_RAW_HEADER_EN
            mq.push_back(16'hA55A);
            mq.push_back(cmd[15:0]);
`endif
          end
        end
        M_CAPTURE: begin
          if (av) begin
            if (can_push) mq.push_back(ad);
            else m_ovf = 1'b1;
            m_rem--;
            if (m_rem == 0) m_mode = M_DRAIN;
          end
        end
        M_DRAIN: if (sz0 == 0) m_mode = M_DONE;
        default: if (fall) m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic wren, input logic [31:0] cmd, input logic av,
                               input logic [15:0] ad, input logic rd, input logic op);
    bus_if.user_w_gs_start_test_wren = wren;
    bus_if.user_w_gs_start_test_data = cmd;
    bus_if.adc_valid                 = av;
    bus_if.adc_data                  = ad;
    bus_if.user_r_gs_raw_signal_rden = rd;
    bus_if.user_r_gs_raw_signal_open = op;
    modelStep(wren, cmd, av, ad, rd, op);
    @(posedge bus_clk);
    #1;
    checkOutput("empty",    32'(bus_if.user_r_gs_raw_signal_empty), 32'(mq.size() == 0));
    checkOutput("eof",      32'(bus_if.user_r_gs_raw_signal_eof),   32'(m_mode == M_DONE));
    checkOutput("busy",     32'(busy),                              32'(m_mode != M_IDLE));
    checkOutput("overflow", 32'(overflow),                          32'(m_ovf));
    checkOutput("data",     32'(bus_if.user_r_gs_raw_signal_data),  32'(m_data));
    checkOutput("full",     32'(bus_if.user_w_gs_start_test_full),  32'd0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic sendCmd(input logic [31:0] c);
    applyStimulus(1'b1, c, 1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic sampleIn(input logic [15:0] d);
    applyStimulus(1'b0, 32'h0, 1'b1, d, 1'b0, 1'b1);
  endtask

  task automatic popOne();
    applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b1);
  endtask

  initial begin
    vec_t tbl[12];
    logic op;
    logic w;
    logic [31:0] c;

    bus_if.user_w_gs_start_test_wren = 1'b0;
    bus_if.user_w_gs_start_test_data = 32'h0;
    bus_if.user_w_gs_start_test_open = 1'b1;
    bus_if.adc_valid                 = 1'b0;
    bus_if.adc_data                  = 16'h0;
    bus_if.user_r_gs_raw_signal_rden = 1'b0;
    bus_if.user_r_gs_raw_signal_open = 1'b1;

    // Reset values
    bus_rst_n = 1'b0;
    repeat (3) @(posedge bus_clk);
    #1;
    checkOutput("rst_empty",    32'(bus_if.user_r_gs_raw_signal_empty), 32'd1);
    checkOutput("rst_eof",      32'(bus_if.user_r_gs_raw_signal_eof),   32'd0);
    checkOutput("rst_busy",     32'(busy),                              32'd0);
    checkOutput("rst_overflow", 32'(overflow),                          32'd0);
    checkOutput("rst_data",     32'(bus_if.user_r_gs_raw_signal_data),  32'd0);
    checkOutput("rst_full",     32'(bus_if.user_w_gs_start_test_full),  32'd0);
    bus_rst_n = 1'b1;

`ifndef GS_RAW_HEADER_EN
    // Directed four-sample capture, read-out and read-side close
    tbl[0]  = mk(1'b1, 32'h4, 1'b0, 16'd0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    tbl[1]  = mk(1'b0, 32'h0, 1'b1, 16'd1, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    tbl[2]  = mk(1'b0, 32'h0, 1'b1, 16'd2, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    tbl[3]  = mk(1'b0, 32'h0, 1'b1, 16'd3, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    tbl[4]  = mk(1'b0, 32'h0, 1'b1, 16'd4, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    tbl[5]  = mk(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    tbl[6]  = mk(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
    tbl[7]  = mk(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 16'd3);
    tbl[8]  = mk(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 16'd4);
    tbl[9]  = mk(1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 1'b0, 16'd4);
    tbl[10] = mk(1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 16'd4);
    tbl[11] = mk(1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, 16'd4);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].wren, tbl[i].cmd, tbl[i].av, tbl[i].ad, tbl[i].rd, tbl[i].op);
      checkOutput($sformatf("tbl%0d_empty", i), 32'(bus_if.user_r_gs_raw_signal_empty), 32'(tbl[i].e_empty));
      checkOutput($sformatf("tbl%0d_eof", i),   32'(bus_if.user_r_gs_raw_signal_eof),   32'(tbl[i].e_eof));
      checkOutput($sformatf("tbl%0d_busy", i),  32'(busy),                              32'(tbl[i].e_busy));
      checkOutput($sformatf("tbl%0d_ovf", i),   32'(overflow),                          32'(tbl[i].e_ovf));
      checkOutput($sformatf("tbl%0d_data", i),  32'(bus_if.user_r_gs_raw_signal_data),  32'(tbl[i].e_data));
    end
`endif

    // Simultaneous push and pop at count 5, then empty read holds data
    sendCmd(32'h8000_0000);
    sendCmd(32'd20);
    for (int i = 0; i < 5; i++) sampleIn(16'(10 + i));
    applyStimulus(1'b0, 32'h0, 1'b1, 16'd15, 1'b1, 1'b1);
    checkOutput("pp_not_empty", 32'(bus_if.user_r_gs_raw_signal_empty), 32'd0);
`ifndef GS_RAW_HEADER_EN
    checkOutput("pp_first", 32'(bus_if.user_r_gs_raw_signal_data), 32'd10);
    for (int i = 0; i < 5; i++) begin
      popOne();
      checkOutput($sformatf("pp_order%0d", i), 32'(bus_if.user_r_gs_raw_signal_data), 32'(11 + i));
    end
    popOne();
    checkOutput("pp_empty_hold", 32'(bus_if.user_r_gs_raw_signal_data), 32'd15);
    checkOutput("pp_empty", 32'(bus_if.user_r_gs_raw_signal_empty), 32'd1);
`endif

    // Abort mid-capture
    sendCmd(32'h8000_0000);
    sendCmd(32'd8);
    for (int i = 0; i < 3; i++) sampleIn(16'(100 + i));
    sendCmd(32'h8000_0000);
    checkOutput("abort_empty", 32'(bus_if.user_r_gs_raw_signal_empty), 32'd1);
    checkOutput("abort_busy",  32'(busy),                              32'd0);
    checkOutput("abort_ovf",   32'(overflow),                          32'd0);

    // Overflow: 1100 strobes into a 1024-word FIFO with no reads
    sendCmd(32'd1100);
    for (int i = 0; i < 1100; i++) sampleIn(16'($urandom));
    checkOutput("ovf_set",       32'(overflow),                          32'd1);
    checkOutput("ovf_busy",      32'(busy),                              32'd1);
    checkOutput("ovf_not_empty", 32'(bus_if.user_r_gs_raw_signal_empty), 32'd0);
    checkOutput("ovf_no_eof",    32'(bus_if.user_r_gs_raw_signal_eof),   32'd0);
    for (int i = 0; i < DEPTH - 1; i++) popOne();
    checkOutput("ovf_one_left", 32'(bus_if.user_r_gs_raw_signal_empty), 32'd0);
    popOne();
    checkOutput("ovf_drained", 32'(bus_if.user_r_gs_raw_signal_empty), 32'd1);
    idleCycle();
    checkOutput("ovf_eof",    32'(bus_if.user_r_gs_raw_signal_eof), 32'd1);
    checkOutput("ovf_sticky", 32'(overflow),                        32'd1);
    sendCmd(32'h8000_0000);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);
    checkOutput("ovf_idle",    32'(busy),     32'd0);

`ifdef GS_RAW_HEADER_EN
    // Header words precede the samples
    sendCmd(32'd2);
    sampleIn(16'd7);
    sampleIn(16'd9);
    popOne();
    checkOutput("hdr_magic", 32'(bus_if.user_r_gs_raw_signal_data), 32'h0000_A55A);
    popOne();
    checkOutput("hdr_n", 32'(bus_if.user_r_gs_raw_signal_data), 32'd2);
    popOne();
    checkOutput("hdr_s0", 32'(bus_if.user_r_gs_raw_signal_data), 32'd7);
    popOne();
    checkOutput("hdr_s1", 32'(bus_if.user_r_gs_raw_signal_data), 32'd9);
    idleCycle();
    checkOutput("hdr_eof", 32'(bus_if.user_r_gs_raw_signal_eof), 32'd1);
    sendCmd(32'h8000_0000);
`endif

    // Randomized traffic against the model
    op = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      w = ($urandom_range(0, 24) == 0);
      c = 32'h0;
      if (w) c = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom_range(0, 24));
      if (op) op = ($urandom_range(0, 39) != 0);
      else    op = ($urandom_range(0, 2) == 0);
      applyStimulus(w, c, ($urandom_range(0, 1) == 1), 16'($urandom),
                    ($urandom_range(0, 2) == 0), op);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
